// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, chip-select polarity and the
// target state encoding. Also consumed by the master.
package spi_pkg;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic CS_ACTIVE      = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with one history flop, giving a synced level plus
// single-clk rise/fall strobes; every instance has the same total delay.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_bit,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_bit};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversamples SCLK/CS/MOSI, receives one LSB-first word per CS
// frame and returns the pre-loaded holding-register word on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txLoad,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  output logic                  frameError,
  output logic                  txUnderrun,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  misoOe
);

  localparam int            CW       = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_bit(SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CS idles inactive, so its synchronizer resets to the inactive level.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(~CS_ACTIVE)) u_sync_cs (
    .clk(clk), .reset(reset), .async_bit(CS),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_bit(MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = ^{sclk_lvl, sclk_rise, cs_lvl, mosi_rise, mosi_fall};

  state_t                state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;

  assign txReady = ~hold_full;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      rxData     <= '0;
      rxValid    <= 1'b0;
      frameError <= 1'b0;
      txUnderrun <= 1'b0;
      MISO       <= 1'b0;
      misoOe     <= 1'b0;
    end else begin
      rxValid    <= 1'b0;
      frameError <= 1'b0;
      txUnderrun <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            count     <= '0;
            misoOe    <= 1'b1;
            hold_full <= 1'b0;
            if (hold_full) begin
              tx_shift <= hold;
              MISO     <= hold[0];
            end else begin
              tx_shift   <= '0;
              MISO       <= 1'b0;
              txUnderrun <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (count == CNT_FULL) begin
            // Word is complete; a coincident CS rise still delivers it.
            rxData  <= rx_shift;
            rxValid <= 1'b1;
            if (cs_rise) begin
              state <= IDLE;
              count <= '0;
            end else begin
              state <= DONE;
            end
          end else if (cs_rise) begin
            frameError <= 1'b1;
            count      <= '0;
            state      <= IDLE;
          end else if (sclk_fall) begin
            rx_shift <= {mosi_lvl, rx_shift[DATA_WIDTH-1:1]};
            tx_shift <= tx_shift >> 1;
            count    <= count + 1'b1;
            if (count != CNT_LAST) MISO <= tx_shift[1];
          end
        end

        DONE: begin
          if (cs_rise) begin
            state <= IDLE;
            count <= '0;
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      if (cs_rise) begin
        misoOe <= 1'b0;
        MISO   <= 1'b0;
      end

      // A load in the frame-start clk sees the old (pre-consume) txReady.
      if (txLoad && !hold_full) begin
        hold      <= txData;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: directed frames push expected pulse events,
// a monitor pops them as the DUT pulses; static outputs are checked inline.
module tb_spi_slave;

  localparam int HALF = 8;  // clk cycles per SCLK half-period

  localparam int EV_RX = 0;
  localparam int EV_FE = 1;
  localparam int EV_UR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] txData;
  logic       txLoad;
  logic       txReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameError;
  logic       txUnderrun;
  logic       busy;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;
  logic       misoOe;

  ev_t exp_q[$];
  int  vectors    = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .txData(txData), .txLoad(txLoad), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid),
    .frameError(frameError), .txUnderrun(txUnderrun), .busy(busy),
    .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .misoOe(misoOe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input int kind, input logic [7:0] data);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d data %h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        miscompares++;
        $display("FAIL event: got kind %0d data %h expected kind %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: sample pulses away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (rxValid)    mon_ev(EV_RX, rxData);
      if (frameError) mon_ev(EV_FE, 8'h00);
      if (txUnderrun) mon_ev(EV_UR, 8'h00);
    end
  end

  task automatic load(input logic [7:0] d);
    txData = d;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
    @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b, output logic m);
    MOSI = b;
    SCLK = 1'b1;
    repeat (HALF) @(negedge clk);
    SCLK = 1'b0;
    m = MISO;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] mo, input int nfalls, output logic [7:0] mi);
    logic m;
    logic b;
    mi = 8'h00;
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nfalls; i++) begin
      b = (i < 8) ? mo[i] : 1'b0;
      sclk_bit(b, m);
      if (i < 8) mi[i] = m;
    end
    CS   = 1'b1;
    MOSI = 1'b0;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txReady"},    32'(txReady),    32'd1);
    chk({tag, "_rxData"},     32'(rxData),     32'h00);
    chk({tag, "_rxValid"},    32'(rxValid),    32'd0);
    chk({tag, "_frameError"}, 32'(frameError), 32'd0);
    chk({tag, "_txUnderrun"}, 32'(txUnderrun), 32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
    chk({tag, "_MISO"},       32'(MISO),       32'd0);
    chk({tag, "_misoOe"},     32'(misoOe),     32'd0);
  endtask

  initial begin
    logic [7:0] mi;
    logic       m;

    reset  = 1'b0;
    txData = 8'h00;
    txLoad = 1'b0;
    SCLK   = 1'b0;
    CS     = 1'b1;
    MOSI   = 1'b0;
    #1;
    chk_reset_vals("por");
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Loaded word returned, master word received.
    load(8'hA5);
    chk("t1_txReady_after_load", 32'(txReady), 32'd0);
    expect_ev(EV_RX, 8'h3C);
    frame(8'h3C, 8, mi);
    chk("t1_miso_word", 32'(mi),     32'hA5);
    chk("t1_rxData",    32'(rxData), 32'h3C);
    chk("t1_misoOe",    32'(misoOe), 32'd0);
    chk("t1_busy",      32'(busy),   32'd0);
    chk("t1_txReady",   32'(txReady), 32'd1);

    // Short frame: abort, rxData preserved.
    expect_ev(EV_UR, 8'h00);
    expect_ev(EV_FE, 8'h00);
    frame(8'hFF, 5, mi);
    chk("t3_rxData_kept", 32'(rxData), 32'h3C);
    chk("t3_misoOe",      32'(misoOe), 32'd0);
    chk("t3_busy",        32'(busy),   32'd0);

    // Second load while full is ignored.
    load(8'h11);
    chk("t4_txReady_full", 32'(txReady), 32'd0);
    load(8'h22);
    expect_ev(EV_RX, 8'hC3);
    frame(8'hC3, 8, mi);
    chk("t4_miso_word", 32'(mi),      32'h11);
    chk("t4_txReady",   32'(txReady), 32'd1);
    chk("t4_rxData",    32'(rxData),  32'hC3);

    // Underrun: master receives zeros.
    expect_ev(EV_UR, 8'h00);
    expect_ev(EV_RX, 8'hFF);
    frame(8'hFF, 8, mi);
    chk("t2_miso_word", 32'(mi),     32'h00);
    chk("t2_rxData",    32'(rxData), 32'hFF);

    // Over-clocked frame: only one word delivered.
    expect_ev(EV_UR, 8'h00);
    expect_ev(EV_RX, 8'h96);
    frame(8'h96, 12, mi);
    chk("t5_rxData", 32'(rxData), 32'h96);
    chk("t5_misoOe", 32'(misoOe), 32'd0);

    // Reset in the middle of a frame.
    expect_ev(EV_UR, 8'h00);
    CS = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) sclk_bit(1'b1, m);
    chk("t6_busy_mid",   32'(busy),   32'd1);
    chk("t6_misoOe_mid", 32'(misoOe), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    CS = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_vals("t6_release");
    load(8'hE7);
    expect_ev(EV_RX, 8'h5A);
    frame(8'h5A, 8, mi);
    chk("t6_miso_word", 32'(mi),     32'hE7);
    chk("t6_rxData",    32'(rxData), 32'h5A);

    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got none expected kind %0d data %h", e.kind, e.data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
